// File: rtl/dpi_call_arbiter.sv
// Round-robin arbiter that shares one host DPI call channel among several bridged call sites.
// One call is in flight at a time and its return value is routed back to the caller that issued it.
module dpi_call_arbiter #(
    parameter int N_CALLERS = 4,
    parameter int N_ARGS    = 2,
    parameter int ARG_W     = 32,
    parameter int FID_W     = 8,
    parameter int RET_W     = 32,
    localparam int IDX_W    = $clog2(N_CALLERS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_CALLERS-1:0]              req_valid,
    output logic [N_CALLERS-1:0]              req_ready,
    input  logic [N_CALLERS*FID_W-1:0]        req_func,
    input  logic [N_CALLERS*N_ARGS*ARG_W-1:0] req_args,
    output logic [N_CALLERS-1:0]              rsp_valid,
    output logic [RET_W-1:0]                  rsp_data,
    output logic                              host_call_valid,
    input  logic                              host_call_ready,
    output logic [IDX_W-1:0]                  host_call_caller,
    output logic [FID_W-1:0]                  host_call_func,
    output logic [N_ARGS*ARG_W-1:0]           host_call_args,
    input  logic                              host_ret_valid,
    output logic                              host_ret_ready,
    input  logic [RET_W-1:0]                  host_ret_data,
    output logic                              busy,
    output logic                              spurious_ret,
    output logic [31:0]                       call_count
);

    localparam int PAY_W = N_ARGS * ARG_W;
    localparam logic [N_CALLERS-1:0] ONE_HOT_BASE = {{(N_CALLERS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    state_t                 state_r;
    logic [IDX_W-1:0]       rr_ptr_r;
    logic [IDX_W-1:0]       caller_r;
    logic [FID_W-1:0]       func_r;
    logic [PAY_W-1:0]       args_r;
    logic [RET_W-1:0]       rsp_data_r;
    logic [N_CALLERS-1:0]   rsp_valid_r;
    logic                   call_valid_r;
    logic                   ret_ready_r;
    logic                   busy_r;
    logic                   spurious_r;
    logic [31:0]            call_count_r;

    logic                   grant_found_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic [IDX_W:0]         cand_sum_s;
    logic [IDX_W-1:0]       cand_idx_s;
    logic [IDX_W-1:0]       rr_next_s;
    logic [FID_W-1:0]       grant_func_s;
    logic [PAY_W-1:0]       grant_args_s;
    logic [N_CALLERS-1:0]   caller_onehot_s;

    // Round-robin search: scan offsets from the farthest down to rr_ptr so the nearest requester wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_sum_s    = '0;
        cand_idx_s    = '0;
        for (int k = N_CALLERS - 1; k >= 0; k--) begin
            cand_sum_s    = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
            cand_idx_s    = (cand_sum_s >= (IDX_W+1)'(N_CALLERS))
                          ? IDX_W'(cand_sum_s - (IDX_W+1)'(N_CALLERS))
                          : cand_sum_s[IDX_W-1:0];
            grant_found_s = grant_found_s | req_valid[cand_idx_s];
            grant_idx_s   = req_valid[cand_idx_s] ? cand_idx_s : grant_idx_s;
        end
    end

    assign rr_next_s       = (grant_idx_s == IDX_W'(N_CALLERS - 1)) ? '0 : grant_idx_s + IDX_W'(1);
    assign grant_func_s    = req_func[int'(grant_idx_s) * FID_W +: FID_W];
    assign grant_args_s    = req_args[int'(grant_idx_s) * PAY_W +: PAY_W];
    assign caller_onehot_s = ONE_HOT_BASE << caller_r;

    // Same-cycle grant: only the round-robin winner sees req_ready, only from IDLE and never in reset.
    always_comb begin
        req_ready = '0;
        if (!rst && (state_r == ST_IDLE) && grant_found_s) begin
            req_ready = ONE_HOT_BASE << grant_idx_s;
        end else begin
            req_ready = '0;
        end
    end

    // Call sequencer: state, latched call, return capture and all registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            caller_r     <= '0;
            func_r       <= '0;
            args_r       <= '0;
            rsp_data_r   <= '0;
            rsp_valid_r  <= '0;
            call_valid_r <= 1'b0;
            ret_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
            spurious_r   <= 1'b0;
            call_count_r <= 32'd0;
        end else begin
            // A return offered while no call is waiting is dropped but remembered until reset.
            if (host_ret_valid && (state_r != ST_WAIT)) begin
                spurious_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        caller_r     <= grant_idx_s;
                        func_r       <= grant_func_s;
                        args_r       <= grant_args_s;
                        rr_ptr_r     <= rr_next_s;
                        call_valid_r <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (host_call_ready) begin
                        call_valid_r <= 1'b0;
                        ret_ready_r  <= 1'b1;
                        state_r      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (host_ret_valid) begin
                        rsp_data_r   <= host_ret_data;
                        rsp_valid_r  <= caller_onehot_s;
                        ret_ready_r  <= 1'b0;
                        call_count_r <= call_count_r + 32'd1;
                        state_r      <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    rsp_valid_r <= '0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    rsp_valid_r  <= '0;
                    call_valid_r <= 1'b0;
                    ret_ready_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid        = rsp_valid_r;
    assign rsp_data         = rsp_data_r;
    assign host_call_valid  = call_valid_r;
    assign host_call_caller = caller_r;
    assign host_call_func   = func_r;
    assign host_call_args   = args_r;
    assign host_ret_ready   = ret_ready_r;
    assign busy             = busy_r;
    assign spurious_ret     = spurious_r;
    assign call_count       = call_count_r;

    dpi_call_arbiter_chk #(
        .N_CALLERS (N_CALLERS),
        .PAY_W     (PAY_W),
        .FID_W     (FID_W),
        .IDX_W     (IDX_W)
    ) u_chk (
        .clk              (clk),
        .rst              (rst),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .host_call_valid  (host_call_valid),
        .host_call_ready  (host_call_ready),
        .host_call_caller (host_call_caller),
        .host_call_func   (host_call_func),
        .host_call_args   (host_call_args)
    );

endmodule

// Protocol checker: grants and responses are one-hot-or-zero and the host payload holds while stalled.
module dpi_call_arbiter_chk #(
    parameter int N_CALLERS = 4,
    parameter int PAY_W     = 64,
    parameter int FID_W     = 8,
    parameter int IDX_W     = 2
) (
    input logic                 clk,
    input logic                 rst,
    input logic [N_CALLERS-1:0] req_ready,
    input logic [N_CALLERS-1:0] rsp_valid,
    input logic                 host_call_valid,
    input logic                 host_call_ready,
    input logic [IDX_W-1:0]     host_call_caller,
    input logic [FID_W-1:0]     host_call_func,
    input logic [PAY_W-1:0]     host_call_args
);

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

    a_rsp_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));

    a_call_stable: assert property (@(posedge clk) disable iff (rst)
        (host_call_valid && !host_call_ready) |=>
        (host_call_valid && $stable(host_call_caller) && $stable(host_call_func) && $stable(host_call_args)));

endmodule

// File: doc/dpi_call_arbiter.md
# dpi_call_arbiter

Shares one host DPI call channel among `N_CALLERS` bridged DPI call sites in an emulated design. Each call site presents a function ID and argument vector. The arbiter grants call sites round-robin, serializes each call to the host transport, waits for the return value and routes it back to the originating call site. It sits between the DPI bridge stubs generated for user call sites and the single host mailbox.

## Interface

Parameters:
- `N_CALLERS`, 4: number of call sites; must be ≥ 2.
- `N_ARGS`, 2: argument words per call.
- `ARG_W`, 32: bits per argument word.
- `FID_W`, 8: function ID width.
- `RET_W`, 32: return value width.
- `IDX_W` (localparam), $clog2(`N_CALLERS`): caller index width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  `N_CALLERS`  per-caller call request.
- `req_ready`  out  `N_CALLERS`  per-caller grant/accept, one-hot or zero.
- `req_func`  in  `N_CALLERS*FID_W`  per-caller function ID, caller i at bits [i*FID_W +: FID_W].
- `req_args`  in  `N_CALLERS*N_ARGS*ARG_W`  per-caller arguments, caller i, arg j at bits [(i*N_ARGS+j)*ARG_W +: ARG_W].
- `rsp_valid`  out  `N_CALLERS`  one-cycle return strobe to the originating caller.
- `rsp_data`  out  `RET_W`  return value, shared by all callers, qualified by `rsp_valid`.
- `host_call_valid`  out  1  call presented to host.
- `host_call_ready`  in  1  host accepts call.
- `host_call_caller`  out  `IDX_W`  granted caller index.
- `host_call_func`  out  `FID_W`  latched function ID.
- `host_call_args`  out  `N_ARGS*ARG_W`  latched arguments.
- `host_ret_valid`  in  1  host return value available.
- `host_ret_ready`  out  1  arbiter accepts return.
- `host_ret_data`  in  `RET_W`  return value.
- `busy`  out  1  high in any state other than IDLE.
- `spurious_ret`  out  1  sticky error flag.
- `call_count`  out  32  count of completed calls; wraps.

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- **IDLE:**
  - Round-robin search of `req_valid` starting at `rr_ptr`.
  - The winner i gets `req_ready[i]=1` combinationally in the same cycle.
  - `req_func[i]`, `req_args[i]` and i are latched into call registers.
  - `rr_ptr` becomes (i+1) mod `N_CALLERS`. Next state is ISSUE.
  - If no request is pending, stay in IDLE and leave `rr_ptr` unchanged.
- **ISSUE:**
  - `host_call_valid=1`, with payload taken from the latched registers.
  - Payload is stable until `host_call_ready`.
  - On `host_call_valid && host_call_ready`, go to WAIT.
- **WAIT:**
  - `host_ret_ready=1`.
  - On `host_ret_valid`, latch `host_ret_data` into `rsp_data` and go to RESPOND.
- **RESPOND:**
  - `rsp_valid[caller]=1` for exactly one cycle.
  - `call_count` increments.
  - Next state is IDLE.
- Only one call is outstanding at a time. Calls are never reordered or dropped.
- Caller obligations:
  - Hold `req_valid` and payload stable until `req_ready`.
  - After being accepted, do not reassert `req_valid` until its `rsp_valid`.
  - These are not checked by the arbiter.
- `host_ret_valid` outside WAIT:
  - The return is ignored and `host_ret_ready` stays 0.
  - `spurious_ret` is set and remains set until reset.
- `rsp_data` holds its last value outside RESPOND.
- `call_count` wraps from 0xFFFFFFFF to 0.

## Timing

- Reset values:
  - State IDLE, `rr_ptr` 0.
  - `req_ready` 0, `rsp_valid` 0, `rsp_data` 0.
  - `host_call_valid` 0, `host_call_caller` 0, `host_call_func` 0, `host_call_args` 0.
  - `host_ret_ready` 0, `busy` 0, `spurious_ret` 0, `call_count` 0.
- Reset mid-operation:
  - Immediately abandons the call: no `rsp_valid` is issued.
  - Any host return that arrives after reset release sets `spurious_ret`.
- Minimum latency, with the grant at cycle T and the host ready/returning immediately:
  - `host_call_valid` at T+1.
  - WAIT at T+2 with a same-cycle return.
  - `rsp_valid` at T+3.
  - Next grant possible at T+4.
- Worst-case wait for caller i: (`N_CALLERS`−1) full calls ahead of it.
- Simultaneous requests are resolved by `rr_ptr` only. The lowest index wins only when `rr_ptr`=0.
- `req_ready` is combinational from `req_valid` and state. All other outputs are registered or decoded from state.

## Test plan

- **Single call:** reset, then caller 1 requests func 0x03, args (5, 7).
  - `req_ready[1]` in the same cycle.
  - `host_call_caller`=1, func=0x03, args={7,5} held through 3 cycles of `host_call_ready`=0.
  - Host returns 12 → `rsp_valid[1]` for one cycle with `rsp_data`=12.
  - `call_count`=1.
- **Round-robin:** callers 0, 2 and 3 request simultaneously after reset.
  - Grant order is 0, 2, 3.
  - Caller 0 re-requests after its response; next grant goes to 0 only after 3.
- **Back-to-back minimum latency:** host always ready and returning immediately.
  - Grants occur every 4 cycles.
  - `rsp_valid` arrives exactly 3 cycles after `req_ready`.
- **Spurious return:** `host_ret_valid` pulsed in IDLE.
  - `spurious_ret`=1, `host_ret_ready`=0.
  - A subsequent normal call completes correctly.
  - The flag remains 1.
- **Reset mid-call:** assert `rst` in WAIT.
  - All outputs return to reset values immediately.
  - No `rsp_valid` is issued.
  - The next request from caller 2 is granted normally with `rr_ptr` starting at 0.
- **Counter wrap:** force `call_count` to 0xFFFFFFFF via a hierarchical deposit; complete one call → `call_count`=0.
